// File: rtl/seq_datapath_pkg.sv
// Shared definitions for seq_datapath: operation codes, controller states and a
// constant-foldable clog2 used to size register indices and shift amounts.
package seq_datapath_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_ROR  = 4'd6,
    OP_ROL  = 4'd7,
    OP_NEG  = 4'd8,
    OP_NOT  = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIV  = 4'd11,
    OP_MFHI = 4'd12,
    OP_MFLO = 4'd13,
    OP_IN   = 4'd14,
    OP_ILL  = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDY  = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_ITER = 3'd4,
    S_DONE = 3'd5
  } state_e;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((32'sd1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/seq_datapath_alu.sv
// Combinational single-cycle ALU of seq_datapath; a is the Y register, b is the
// operand on the shared bus. MUL/DIV are handled iteratively by the top.
module seq_datapath_alu
  import seq_datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] y
);

  localparam int SH_W = clog2(DATA_W);

  logic [SH_W-1:0] sh_s;
  logic [SH_W:0]   sh_inv_s;

  // A zero rotate amount makes the complementary shift equal DATA_W, which yields zero.
  assign sh_s     = b[SH_W-1:0];
  assign sh_inv_s = (SH_W+1)'(DATA_W) - {1'b0, sh_s};

  // Result select per operation code
  always_comb begin
    y = {DATA_W{1'b0}};
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SHR:  y = a >> sh_s;
      OP_SHL:  y = a << sh_s;
      OP_ROR:  y = (a >> sh_s) | (a << sh_inv_s);
      OP_ROL:  y = (a << sh_s) | (a >> sh_inv_s);
      OP_NEG:  y = -b;
      OP_NOT:  y = ~b;
      OP_MFHI: y = hi;
      OP_MFLO: y = lo;
      OP_IN:   y = in_port;
      default: y = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/seq_datapath.sv
// Bus-based sequential datapath with register file, Y/Z/HI/LO and a multi-cycle
// controller. Define SEQ_DATAPATH_MULDIV_EN to build the iterative MUL/DIV unit.
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  localparam int REG_AW   = clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rc,
  input  logic [DATA_W-1:0] in_port,
  input  logic              ext_wr_en,
  input  logic [REG_AW-1:0] ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic [REG_AW-1:0] dbg_rd_addr,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

`ifdef SEQ_DATAPATH_MULDIV_EN
  localparam int Z_W  = 2 * DATA_W;
  localparam int SH_W = clog2(DATA_W);
`else
  // Without MUL/DIV only ZLow ever carries a result.
  localparam int Z_W  = DATA_W;
`endif

  state_e            state_r, state_nx_s;
  op_e               op_r;
  logic [REG_AW-1:0] ra_r, rb_r, rc_r;
  logic              err_pend_r, done_r, err_r, illegal_s;
  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [DATA_W-1:0] y_r, hi_r, lo_r;
  logic [Z_W-1:0]    z_r;
  logic [DATA_W-1:0] bus_s, rb_data_s, alu_y_s;

  assign rb_data_s   = regs_r[rb_r];
  assign dbg_rd_data = regs_r[dbg_rd_addr];
  assign busy        = (state_r != S_IDLE);
  assign done        = done_r;
  assign err         = err_r;
  assign hi_out      = hi_r;
  assign lo_out      = lo_r;

`ifdef SEQ_DATAPATH_MULDIV_EN
  assign illegal_s = (op == OP_ILL);

  logic [SH_W-1:0]   cnt_r;
  logic [DATA_W-1:0] mcand_r, opa_mag_s, opb_mag_s, quot_s, rem_s;
  logic              neg_q_r, neg_r_r, muldiv_s, div_zero_s, last_s;
  logic [DATA_W:0]   mul_sum_s, div_sh_s, div_diff_s;
  logic [Z_W-1:0]    mul_nx_s, div_nx_s, iter_nx_s, prod_s;

  // Both algorithms work on magnitudes in Z; signs are reapplied on the last step.
  assign muldiv_s   = (op_r == OP_MUL) || (op_r == OP_DIV);
  assign div_zero_s = (op_r == OP_DIV) && (rb_data_s == {DATA_W{1'b0}});
  assign last_s     = (cnt_r == SH_W'(DATA_W - 1));
  assign opa_mag_s  = bus_s[DATA_W-1] ? -bus_s : bus_s;
  assign opb_mag_s  = rb_data_s[DATA_W-1] ? -rb_data_s : rb_data_s;
  assign mul_sum_s  = {1'b0, z_r[Z_W-1:DATA_W]} +
                      (z_r[0] ? {1'b0, mcand_r} : {(DATA_W+1){1'b0}});
  assign mul_nx_s   = {mul_sum_s, z_r[DATA_W-1:1]};
  assign div_sh_s   = {z_r[Z_W-1:DATA_W], z_r[DATA_W-1]};
  assign div_diff_s = div_sh_s - {1'b0, mcand_r};
  assign div_nx_s   = div_diff_s[DATA_W] ? {div_sh_s[DATA_W-1:0], z_r[DATA_W-2:0], 1'b0}
                                         : {div_diff_s[DATA_W-1:0], z_r[DATA_W-2:0], 1'b1};
  assign iter_nx_s  = (op_r == OP_MUL) ? mul_nx_s : div_nx_s;
  assign prod_s     = neg_q_r ? -iter_nx_s : iter_nx_s;
  assign quot_s     = neg_q_r ? -iter_nx_s[DATA_W-1:0] : iter_nx_s[DATA_W-1:0];
  assign rem_s      = neg_r_r ? -iter_nx_s[Z_W-1:DATA_W] : iter_nx_s[Z_W-1:DATA_W];
`else
  assign illegal_s = (op == OP_ILL) || (op == OP_MUL) || (op == OP_DIV);
`endif

  // Shared bus: exactly one source per controller state
  always_comb begin
    bus_s = {DATA_W{1'b0}};
    case (state_r)
      S_LDY:   bus_s = regs_r[ra_r];
      S_EXEC:  bus_s = rb_data_s;
      S_WB:    bus_s = z_r[DATA_W-1:0];
      default: bus_s = {DATA_W{1'b0}};
    endcase
  end

  seq_datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op_r),
    .a       (y_r),
    .b       (bus_s),
    .hi      (hi_r),
    .lo      (lo_r),
    .in_port (in_port),
    .y       (alu_y_s)
  );

  // Controller state register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Controller next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nx_s = illegal_s ? S_DONE : S_LDY;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_LDY: begin
`ifdef SEQ_DATAPATH_MULDIV_EN
        if (muldiv_s) begin
          state_nx_s = div_zero_s ? S_DONE : S_ITER;
        end else begin
          state_nx_s = S_EXEC;
        end
`else
        state_nx_s = S_EXEC;
`endif
      end
      S_EXEC:  state_nx_s = S_WB;
      S_WB:    state_nx_s = S_DONE;
`ifdef SEQ_DATAPATH_MULDIV_EN
      S_ITER:  state_nx_s = last_s ? S_DONE : S_ITER;
`endif
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Datapath registers, register file and status outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      op_r       <= OP_ADD;
      ra_r       <= {REG_AW{1'b0}};
      rb_r       <= {REG_AW{1'b0}};
      rc_r       <= {REG_AW{1'b0}};
      y_r        <= {DATA_W{1'b0}};
      z_r        <= {Z_W{1'b0}};
      hi_r       <= {DATA_W{1'b0}};
      lo_r       <= {DATA_W{1'b0}};
      err_pend_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
`ifdef SEQ_DATAPATH_MULDIV_EN
      cnt_r      <= {SH_W{1'b0}};
      mcand_r    <= {DATA_W{1'b0}};
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (ext_wr_en) begin
            regs_r[ext_wr_addr] <= ext_wr_data;
          end
          if (start) begin
            op_r       <= op_e'(op);
            ra_r       <= ra;
            rb_r       <= rb;
            rc_r       <= rc;
            err_pend_r <= illegal_s;
          end
        end
        S_LDY: begin
          y_r <= bus_s;
`ifdef SEQ_DATAPATH_MULDIV_EN
          err_pend_r <= div_zero_s;
          cnt_r      <= {SH_W{1'b0}};
          mcand_r    <= (op_r == OP_MUL) ? opa_mag_s : opb_mag_s;
          z_r        <= {{DATA_W{1'b0}}, (op_r == OP_MUL) ? opb_mag_s : opa_mag_s};
          neg_q_r    <= bus_s[DATA_W-1] ^ rb_data_s[DATA_W-1];
          neg_r_r    <= bus_s[DATA_W-1];
`endif
        end
        S_EXEC: z_r <= Z_W'(alu_y_s);
        S_WB:   regs_r[rc_r] <= bus_s;
`ifdef SEQ_DATAPATH_MULDIV_EN
        S_ITER: begin
          cnt_r <= cnt_r + SH_W'(1);
          z_r   <= iter_nx_s;
          if (last_s) begin
            if (op_r == OP_MUL) begin
              hi_r <= prod_s[Z_W-1:DATA_W];
              lo_r <= prod_s[DATA_W-1:0];
            end else begin
              hi_r <= rem_s;
              lo_r <= quot_s;
            end
          end
        end
`endif
        default: ;
      endcase
      done_r <= (state_r == S_DONE);
      err_r  <= (state_r == S_DONE) && err_pend_r;
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// Directed self-checking bench for seq_datapath (32-bit/16 regs plus a 16-bit/8 regs rerun).
module tb_seq_datapath;
  import seq_datapath_pkg::*;

  logic        clk = 1'b0;
  logic        clr, start, ext_wr_en, busy, done, err;
  logic [3:0]  op, ra, rb, rc, ext_wr_addr, dbg_rd_addr;
  logic [31:0] in_port, ext_wr_data, dbg_rd_data, hi_out, lo_out;

  logic        start2, ext_wr_en2, busy2, done2, err2;
  logic [3:0]  op2;
  logic [2:0]  ra2, rb2, rc2, ext_wr_addr2, dbg_rd_addr2;
  logic [15:0] in_port2, ext_wr_data2, dbg_rd_data2, hi_out2, lo_out2;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seq_datapath #(.DATA_W(32), .NUM_REGS(16)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .in_port(in_port), .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr),
    .ext_wr_data(ext_wr_data), .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
    .busy(busy), .done(done), .err(err), .hi_out(hi_out), .lo_out(lo_out)
  );

  seq_datapath #(.DATA_W(16), .NUM_REGS(8)) dut16 (
    .clk(clk), .clr(clr), .start(start2), .op(op2), .ra(ra2), .rb(rb2), .rc(rc2),
    .in_port(in_port2), .ext_wr_en(ext_wr_en2), .ext_wr_addr(ext_wr_addr2),
    .ext_wr_data(ext_wr_data2), .dbg_rd_addr(dbg_rd_addr2), .dbg_rd_data(dbg_rd_data2),
    .busy(busy2), .done(done2), .err(err2), .hi_out(hi_out2), .lo_out(lo_out2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    ext_wr_en = 1'b1; ext_wr_addr = a; ext_wr_data = d;
    @(posedge clk); #1;
    ext_wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] e);
    dbg_rd_addr = a; #1;
    check(tag, 64'(dbg_rd_data), 64'(e));
  endtask

  // Issues one op and returns the number of edges from the accepting edge to done.
  task automatic run_op(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, output int edges, output logic err_seen,
                        output logic busy_seen);
    op = o; ra = a; rb = b; rc = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_seen = busy;
    edges = -1;
    err_seen = 1'bx;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = k;
        err_seen = err;
        break;
      end
    end
  endtask

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  vec_t vecs [15];
  int   edges;
  logic err_seen, busy_seen, done_seen;

  initial begin
    vecs = '{
      '{OP_ADD,  32'h0000_0007, 32'h0000_0005, 32'h0000_000C},
      '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
      '{OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE},
      '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200},
      '{OP_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F},
      '{OP_SHR,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000},
      '{OP_SHL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000},
      '{OP_ROR,  32'h0000_0001, 32'h0000_0001, 32'h8000_0000},
      '{OP_ROR,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678},
      '{OP_ROL,  32'h8000_0001, 32'h0000_0001, 32'h0000_0003},
      '{OP_NEG,  32'h0000_0063, 32'h0000_0005, 32'hFFFF_FFFB},
      '{OP_NOT,  32'h1234_5678, 32'h0F0F_0F0F, 32'hF0F0_F0F0},
      '{OP_IN,   32'h0000_0001, 32'h0000_0002, 32'hCAFE_BABE},
      '{OP_MFHI, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000},
      '{OP_MFLO, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000}
    };
    clr = 1'b1; start = 1'b0; op = 4'd0; ra = 4'd0; rb = 4'd0; rc = 4'd0;
    in_port = 32'hCAFE_BABE; ext_wr_en = 1'b0; ext_wr_addr = 4'd0;
    ext_wr_data = 32'd0; dbg_rd_addr = 4'd0;
    start2 = 1'b0; op2 = 4'd0; ra2 = 3'd0; rb2 = 3'd0; rc2 = 3'd0; in_port2 = 16'd0;
    ext_wr_en2 = 1'b0; ext_wr_addr2 = 3'd0; ext_wr_data2 = 16'd0; dbg_rd_addr2 = 3'd0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_hi", 64'(hi_out), 64'd0);
    check("reset_lo", 64'(lo_out), 64'd0);
    rd_chk("reset_r5", 4'd5, 32'd0);

    for (int i = 0; i < 15; i++) begin
      wr(4'd1, vecs[i].a);
      wr(4'd2, vecs[i].b);
      wr(4'd3, 32'h5A5A_5A5A);
      run_op(vecs[i].op, 4'd1, 4'd2, 4'd3, edges, err_seen, busy_seen);
      check($sformatf("alu%0d_edges", i), 64'(edges), 64'd4);
      check($sformatf("alu%0d_err", i), 64'(err_seen), 64'd0);
      rd_chk($sformatf("alu%0d_r3", i), 4'd3, vecs[i].y);
      if (i == 0) check("alu0_busy", 64'(busy_seen), 64'd1);
    end

    // SUB R2-R1 with both zero
    wr(4'd1, 32'd0); wr(4'd2, 32'd0); wr(4'd5, 32'hDEAD_BEEF);
    run_op(OP_SUB, 4'd2, 4'd1, 4'd5, edges, err_seen, busy_seen);
    rd_chk("sub_zero", 4'd5, 32'd0);

    // ra = rb = rc: read-then-write
    wr(4'd6, 32'd3);
    run_op(OP_ADD, 4'd6, 4'd6, 4'd6, edges, err_seen, busy_seen);
    rd_chk("self_add", 4'd6, 32'd6);

    // Illegal op: immediate done with err, no register change
    wr(4'd3, 32'h3333_3333);
    run_op(OP_ILL, 4'd1, 4'd2, 4'd3, edges, err_seen, busy_seen);
    check("ill_edges", 64'(edges), 64'd1);
    check("ill_err", 64'(err_seen), 64'd1);
    check("ill_busy", 64'(busy_seen), 64'd1);
    rd_chk("ill_r3", 4'd3, 32'h3333_3333);

`ifdef SEQ_DATAPATH_MULDIV_EN
    wr(4'd1, 32'hFFFF_FFFD); wr(4'd2, 32'd7); wr(4'd3, 32'h1111_1111);
    run_op(OP_MUL, 4'd1, 4'd2, 4'd3, edges, err_seen, busy_seen);
    check("mul_edges", 64'(edges), 64'd34);
    check("mul_err", 64'(err_seen), 64'd0);
    check("mul_hi", 64'(hi_out), 64'hFFFF_FFFF);
    check("mul_lo", 64'(lo_out), 64'hFFFF_FFEB);
    rd_chk("mul_r3", 4'd3, 32'h1111_1111);
    run_op(OP_MFLO, 4'd1, 4'd2, 4'd4, edges, err_seen, busy_seen);
    rd_chk("mflo", 4'd4, 32'hFFFF_FFEB);

    wr(4'd1, 32'hFFFF_FFF9); wr(4'd2, 32'd2);
    run_op(OP_DIV, 4'd1, 4'd2, 4'd3, edges, err_seen, busy_seen);
    check("div_edges", 64'(edges), 64'd34);
    check("div_lo", 64'(lo_out), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi_out), 64'hFFFF_FFFF);

    wr(4'd1, 32'd100); wr(4'd2, 32'hFFFF_FFF9);
    run_op(OP_DIV, 4'd1, 4'd2, 4'd3, edges, err_seen, busy_seen);
    check("div2_lo", 64'(lo_out), 64'hFFFF_FFF2);
    check("div2_hi", 64'(hi_out), 64'h0000_0002);

    wr(4'd2, 32'd0);
    run_op(OP_DIV, 4'd1, 4'd2, 4'd3, edges, err_seen, busy_seen);
    check("div0_edges", 64'(edges), 64'd2);
    check("div0_err", 64'(err_seen), 64'd1);
    check("div0_lo", 64'(lo_out), 64'hFFFF_FFF2);
    check("div0_hi", 64'(hi_out), 64'h0000_0002);

    wr(4'd1, 32'hFFFF_FFFD); wr(4'd2, 32'd7);
    op = OP_MUL; ra = 4'd1; rb = 4'd2; rc = 4'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
`else
    wr(4'd1, 32'd9); wr(4'd2, 32'd3);
    run_op(OP_MUL, 4'd1, 4'd2, 4'd3, edges, err_seen, busy_seen);
    check("mul_off_edges", 64'(edges), 64'd1);
    check("mul_off_err", 64'(err_seen), 64'd1);
    check("mul_off_hi", 64'(hi_out), 64'd0);
    check("mul_off_lo", 64'(lo_out), 64'd0);
    rd_chk("mul_off_r3", 4'd3, 32'h3333_3333);
    run_op(OP_DIV, 4'd1, 4'd2, 4'd3, edges, err_seen, busy_seen);
    check("div_off_err", 64'(err_seen), 64'd1);

    op = OP_ADD; ra = 4'd1; rb = 4'd2; rc = 4'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
`endif
    // Abort mid-operation with clr
    #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    check("clr_no_done", 64'(done_seen), 64'd0);
    check("clr_hi", 64'(hi_out), 64'd0);
    check("clr_lo", 64'(lo_out), 64'd0);
    for (int r = 0; r < 16; r++) begin
      rd_chk($sformatf("clr_r%0d", r), 4'(r), 32'd0);
    end

    // start and ext_wr_en while busy are ignored
    wr(4'd1, 32'd7); wr(4'd2, 32'd5); wr(4'd4, 32'h44);
    op = OP_ADD; ra = 4'd1; rb = 4'd2; rc = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    op = OP_SUB; rc = 4'd4;
    ext_wr_en = 1'b1; ext_wr_addr = 4'd1; ext_wr_data = 32'd99;
    edges = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = k;
        break;
      end
    end
    start = 1'b0; ext_wr_en = 1'b0;
    check("busy_ign_edges", 64'(edges), 64'd4);
    rd_chk("busy_ign_r3", 4'd3, 32'd12);
    rd_chk("busy_ign_r1", 4'd1, 32'd7);
    rd_chk("busy_ign_r4", 4'd4, 32'h44);
    repeat (3) @(posedge clk);
    #1 check("busy_ign_noqueue", 64'(busy), 64'd0);

    // 16-bit, 8-register instance: ADD rerun
    ext_wr_en2 = 1'b1; ext_wr_addr2 = 3'd1; ext_wr_data2 = 16'd7;
    @(posedge clk); #1 ext_wr_addr2 = 3'd2; ext_wr_data2 = 16'd5;
    @(posedge clk); #1 ext_wr_en2 = 1'b0;
    op2 = OP_ADD; ra2 = 3'd1; rb2 = 3'd2; rc2 = 3'd3; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    edges = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done2) begin
        edges = k;
        err_seen = err2;
        break;
      end
    end
    check("w16_edges", 64'(edges), 64'd4);
    check("w16_err", 64'(err_seen), 64'd0);
    dbg_rd_addr2 = 3'd3; #1;
    check("w16_r3", 64'(dbg_rd_data2), 64'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_datapath.md
SEQ_DATAPATH -- requirements
Module: seq_datapath

Interface
REQ-001 Parameter DATA_W, default 32, bus/register width (8..64, even).
REQ-002 Parameter NUM_REGS, default 16, general registers (power of two, 2..32); REG_AW = clog2(NUM_REGS).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 clr  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 op  in  4  operation code (Function).
REQ-007 ra, rb, rc  in  REG_AW each  source A, source B, destination register indices.
REQ-008 in_port  in  DATA_W  external input operand.
REQ-009 ext_wr_en / ext_wr_addr / ext_wr_data  in  1 / REG_AW / DATA_W  register preload port.
REQ-010 dbg_rd_addr  in  REG_AW; dbg_rd_data  out  DATA_W  combinational register read.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle registered completion pulse.
REQ-013 err  out  1  registered; valid with done (illegal op or divide by zero).
REQ-014 hi_out, lo_out  out  DATA_W  HI and LO register contents.

Function
REQ-015 Single shared bus; one source drives it per cycle; datapath registers Y, Z (2*DATA_W, ZHigh/ZLow), HI, LO, R[0..NUM_REGS-1].
REQ-016 Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR logical, 5 SHL, 6 ROR, 7 ROL, 8 NEG, 9 NOT, 10 MUL signed, 11 DIV signed, 12 MFHI, 13 MFLO, 14 IN, 15 illegal.
REQ-017 Shift/rotate amount = R[rb][clog2(DATA_W)-1:0]; NEG/NOT use R[rb] only; ADD/SUB wrap modulo 2^DATA_W.
REQ-018 States: IDLE, LDY, EXEC, WB, ITER, DONE.
REQ-019 IDLE & start: latch op/ra/rb/rc -> LDY; illegal op -> DONE with err=1, no register change.
REQ-020 LDY: Y <= R[ra]; -> ITER for MUL/DIV, else -> EXEC.
REQ-021 EXEC: Z <= ALU(Y, R[rb]) (MFHI/MFLO/IN: Z low <= HI/LO/in_port); -> WB.
REQ-022 WB: R[rc] <= ZLow; -> DONE.
REQ-023 DONE: done=1 for exactly one cycle; -> IDLE; start accepted again the next cycle.
REQ-024 Single-cycle ops: done high on the 4th rising edge after the accepting edge; R[rc] visible on dbg_rd_data from that same edge.
REQ-025 MUL: shift-add over exactly DATA_W ITER cycles; {HI,LO} <= 2*DATA_W signed product; R[rc] unchanged.
REQ-026 DIV: restoring divide over exactly DATA_W ITER cycles; LO <= quotient truncated toward zero, HI <= remainder with dividend sign.
REQ-027 DIV with R[rb]=0: skip ITER, HI/LO unchanged, err=1 with done.
REQ-028 ext_wr_en honoured only in IDLE; ignored while busy.
REQ-029 start while busy ignored, not queued.
REQ-030 Operand registers read at use time; ra=rb=rc permitted and behaves as sequential read-then-write.

Reset
REQ-031 clr: state=IDLE, all R, Y, Z, HI, LO = 0, busy=done=err=0; takes priority over every other input.
REQ-032 clr mid-operation aborts it; no done pulse; no partial result retained.

Configuration
REQ-033 Macro SEQ_DATAPATH_MULDIV_EN defined: MUL/DIV as above.
REQ-034 Macro undefined: ITER logic absent; ops 10/11 treated as illegal (REQ-019); HI/LO writable only via reset (remain 0).

Structure
REQ-035 Shared package seq_datapath_pkg holds op enum, state enum, and clog2 helper.
REQ-036 One sub-module seq_datapath_alu (combinational single-cycle ALU); register file, bus mux, FSM and iterative MUL/DIV live in the top.

Verification
REQ-037 Preload R1=7, R2=5; ADD ra=1 rb=2 rc=3 -> done on 4th edge, R3=12, err=0.
REQ-038 DATA_W=32: R1=0x80000001, R2=1, ROL -> rc=0x00000003; SUB R2-R1 with R1=0, R2=0 (ra=2) -> 0x00000000.
REQ-039 MULDIV_EN: R1=-3, R2=7, MUL -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, done at edge 34 after accept; DIV R1=-7,R2=2 -> LO=-3, HI=-1.
REQ-040 DIV by R2=0 -> err=1 with done, HI/LO unchanged; op=15 -> err=1, no register change.
REQ-041 clr asserted during MUL ITER -> busy=0 next edge, no done, all registers 0.
REQ-042 start and ext_wr_en asserted while busy -> ignored; NUM_REGS=8, DATA_W=16 rerun of REQ-037 passes.
